// File: rtl/param_shift_register.sv
// param_shift_register
//   Parametrised load/shift register. Supports a parallel load, a single-step
//   shift, and an autonomous burst of burst_len steps with a busy/done
//   handshake. Shifts can be logical, rotate or arithmetic, in either
//   direction, and an illegal control combination raises a sticky err flag.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   load_en      in   load data_in (highest priority; aborts a burst)
//   data_in      in   [WIDTH-1:0] parallel load value
//   shift_en     in   single-step shift (honoured only while idle)
//   dir          in   0 = right (toward LSB), 1 = left
//   mode         in   00 logical, 01 rotate, 10 arithmetic, 11 reserved
//   serial_in    in   fill bit for logical shifts
//   burst_start  in   start an autonomous shift of burst_len steps
//   burst_len    in   [LEN_W-1:0] step count, 0 allowed
//   err_clr      in   clear err (a simultaneous set wins)
//   data_out     out  [WIDTH-1:0] register contents
//   serial_out   out  bit most recently shifted out / wrapped
//   busy         out  burst in progress
//   done         out  one-cycle pulse when a burst completes
//   err          out  sticky illegal-condition flag
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             bdir_q, bdir_d;
  logic [1:0]       bmode_q, bmode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             err_set;
  logic             step_en;
  logic             step_dir;
  logic [1:0]       step_mode;
  logic [WIDTH:0]   step_res;

  // One shift position. Result is {departing bit, new register value}.
  // The reserved mode falls through to a logical shift.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic             dir_i,
    input logic [1:0]       mode_i,
    input logic             sin
  );
    logic fill;
    if (dir_i) begin
      case (mode_i)
        2'b01:   fill = d[WIDTH-1];
        2'b10:   fill = 1'b0;
        default: fill = sin;
      endcase
      shift_step = {d[WIDTH-1], d[WIDTH-2:0], fill};
    end else begin
      case (mode_i)
        2'b01:   fill = d[0];
        2'b10:   fill = d[WIDTH-1];
        default: fill = sin;
      endcase
      shift_step = {d[0], fill, d[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bdir_d    = bdir_q;
    bmode_d   = bmode_q;
    data_d    = data_q;
    sout_d    = sout_q;
    done_d    = 1'b0;
    err_set   = 1'b0;
    step_en   = 1'b0;
    step_dir  = dir;
    step_mode = mode;

    if (load_en) begin
      // Load wins over everything and silently aborts a running burst.
      data_d  = data_in;
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_set = shift_en | burst_start;
    end else if (state_q == ST_SHIFT) begin
      // Requests arriving mid-burst are ignored but flagged.
      err_set   = shift_en | burst_start;
      step_en   = 1'b1;
      step_dir  = bdir_q;
      step_mode = bmode_q;
      cnt_d     = cnt_q - 1'b1;
      if (cnt_q == LEN_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (burst_start) begin
      bdir_d  = dir;
      bmode_d = mode;
      if (burst_len == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = burst_len;
      end
    end else if (shift_en) begin
      step_en = 1'b1;
    end

    step_res = shift_step(data_q, step_dir, step_mode, serial_in);
    if (step_en) begin
      data_d = step_res[WIDTH-1:0];
      sout_d = step_res[WIDTH];
      if (step_mode == 2'b11) begin
        err_set = 1'b1;
      end
    end

    // Set has priority over clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bdir_q  <= 1'b0;
      bmode_q <= 2'b00;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bdir_q  <= bdir_d;
      bmode_q <= bmode_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = (state_q == ST_SHIFT);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_param_shift_register.sv
module tb_param_shift_register;
  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_en;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic             dir;
  logic [1:0]       mode;
  logic             serial_in;
  logic             burst_start;
  logic [LEN_W-1:0] burst_len;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  param_shift_register #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .dir        (dir),
    .mode       (mode),
    .serial_in  (serial_in),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural reference: register value, flags and remaining burst steps.
  logic [WIDTH-1:0] m_data;
  logic             m_sout, m_busy, m_done, m_err;
  int               m_left;
  logic             m_bdir;
  logic [1:0]       m_bmode;

  task automatic m_reset();
    m_data = '0; m_sout = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_left = 0; m_bdir = 0; m_bmode = 0;
  endtask

  task automatic m_shift(input logic dr, input logic [1:0] md, input logic sin, inout logic set);
    int unsigned v;
    int unsigned top;
    logic        fill;
    v   = m_data;
    top = 1 << (WIDTH - 1);
    if (!dr) begin
      m_sout = v % 2;
      fill = (md == 1) ? (v % 2 == 1) : (md == 2) ? (v >= top) : sin;
      v = v / 2 + (fill ? top : 0);
    end else begin
      m_sout = (v >= top);
      fill = (md == 1) ? (v >= top) : (md == 2) ? 1'b0 : sin;
      v = (v * 2) % (1 << WIDTH) + (fill ? 1 : 0);
    end
    m_data = WIDTH'(v);
    if (md == 3) set = 1;
  endtask

  task automatic m_step();
    logic set;
    logic nd;
    set = 0;
    nd  = 0;
    if (load_en) begin
      if (shift_en || burst_start) set = 1;
      m_data = data_in;
      m_busy = 0;
      m_left = 0;
    end else if (m_busy) begin
      if (shift_en || burst_start) set = 1;
      m_shift(m_bdir, m_bmode, serial_in, set);
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        nd = 1;
      end
    end else if (burst_start) begin
      m_bdir  = dir;
      m_bmode = mode;
      if (burst_len == 0) nd = 1;
      else begin
        m_busy = 1;
        m_left = int'(burst_len);
      end
    end else if (shift_en) begin
      m_shift(dir, mode, serial_in, set);
    end
    m_done = nd;
    if (set) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic compare(input string tag);
    check({tag, ".data"}, 32'(data_out),   32'(m_data));
    check({tag, ".sout"}, 32'(serial_out), 32'(m_sout));
    check({tag, ".busy"}, 32'(busy),       32'(m_busy));
    check({tag, ".done"}, 32'(done),       32'(m_done));
    check({tag, ".err"},  32'(err),        32'(m_err));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    m_step();
    #1;
    compare(tag);
  endtask

  task automatic idle_inputs();
    load_en = 0; data_in = '0; shift_en = 0; dir = 0; mode = 0;
    serial_in = 0; burst_start = 0; burst_len = '0; err_clr = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    m_reset();
    #1;
    compare("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Logical right, single steps
    load_en = 1; data_in = 8'h80; cycle("ld80"); load_en = 0;
    shift_en = 1; dir = 0; mode = 2'b00; serial_in = 0;
    repeat (7) cycle("lsr");
    check("lsr7.data", 32'(data_out), 32'h01);
    cycle("lsr8");
    check("lsr8.data", 32'(data_out), 32'h00);
    check("lsr8.sout", 32'(serial_out), 32'h1);
    shift_en = 0;

    // Rotate-left burst of 3
    load_en = 1; data_in = 8'hA5; cycle("ldA5"); load_en = 0;
    burst_start = 1; burst_len = 3; dir = 1; mode = 2'b01;
    cycle("rolE0"); burst_start = 0;
    check("rol.busy0", 32'(busy), 32'h1);
    cycle("rolE1");
    check("rol.busy1", 32'(busy), 32'h1);
    cycle("rolE2");
    check("rol.busy2", 32'(busy), 32'h1);
    cycle("rolE3");
    check("rol.data", 32'(data_out), 32'h2D);
    check("rol.sout", 32'(serial_out), 32'h1);
    check("rol.done", 32'(done), 32'h1);
    check("rol.busy3", 32'(busy), 32'h0);
    cycle("rolE4");
    check("rol.done_end", 32'(done), 32'h0);

    // Arithmetic right
    load_en = 1; data_in = 8'h90; cycle("ld90"); load_en = 0;
    shift_en = 1; dir = 0; mode = 2'b10;
    cycle("asr1");
    check("asr1.data", 32'(data_out), 32'hC8);
    cycle("asr2");
    check("asr2.data", 32'(data_out), 32'hE4);
    check("asr2.sout", 32'(serial_out), 32'h0);
    shift_en = 0; mode = 0;

    // Load/shift conflict and sticky err
    load_en = 1; shift_en = 1; data_in = 8'h3C; cycle("conf");
    check("conf.data", 32'(data_out), 32'h3C);
    check("conf.err", 32'(err), 32'h1);
    load_en = 0; shift_en = 0;
    repeat (2) cycle("sticky");
    check("sticky.err", 32'(err), 32'h1);
    err_clr = 1; cycle("clr"); err_clr = 0;
    check("clr.err", 32'(err), 32'h0);

    // Load aborts a burst
    load_en = 1; data_in = 8'hFF; cycle("ldFF"); load_en = 0;
    burst_start = 1; burst_len = 5; dir = 0; mode = 2'b00; serial_in = 0;
    cycle("abE0"); burst_start = 0;
    cycle("abE1");
    check("ab.busy2", 32'(busy), 32'h1);
    load_en = 1; data_in = 8'h11; cycle("abLd"); load_en = 0;
    check("ab.data", 32'(data_out), 32'h11);
    check("ab.busy", 32'(busy), 32'h0);
    check("ab.err", 32'(err), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle("abPost");
      check("ab.nodone", 32'(done), 32'h0);
    end

    // Zero-length burst
    load_en = 1; data_in = 8'h5A; cycle("ld5A"); load_en = 0;
    burst_start = 1; burst_len = 0; cycle("z0"); burst_start = 0;
    check("z.done", 32'(done), 32'h1);
    check("z.busy", 32'(busy), 32'h0);
    check("z.data", 32'(data_out), 32'h5A);
    cycle("z1");
    check("z.done_end", 32'(done), 32'h0);

    // Asynchronous reset mid-burst
    load_en = 1; data_in = 8'hC3; cycle("ldC3"); load_en = 0;
    burst_start = 1; burst_len = 6; dir = 1; mode = 2'b01; cycle("rsE0"); burst_start = 0;
    cycle("rsE1");
    rst_n = 0;
    #1;
    m_reset();
    check("rst.data", 32'(data_out), 32'h0);
    check("rst.sout", 32'(serial_out), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle_inputs();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      load_en     = ($urandom_range(0, 11) == 0);
      data_in     = WIDTH'($urandom);
      shift_en    = ($urandom_range(0, 3) == 0);
      burst_start = ($urandom_range(0, 7) == 0);
      burst_len   = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      dir         = 1'($urandom_range(0, 1));
      serial_in   = 1'($urandom_range(0, 1));
      err_clr     = ($urandom_range(0, 15) == 0);
      if (burst_start) mode = 2'($urandom_range(0, 2));
      else             mode = 2'($urandom_range(0, 3));
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
